clock_set_ctrl: RTL and testbench

- Time-setting controller for the hh:mm:ss timekeeper.
- Sequences RUN -> set-hours -> set-minutes -> commit from debounced buttons.
- Gates the 1 Hz advance while editing, then issues a single load of edited hr/min; the timekeeper clears seconds on load.
- Sits between the button debouncers and the timekeeper counters, same system clock.

---
 rtl/clock_set_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the hh:mm:ss timekeeper.
// Walks RUN -> SET_HR -> SET_MIN -> COMMIT on debounced button rises. While
// editing it blocks the 1 Hz advance. On commit it issues one load strobe
// carrying the edited hours and minutes.
// Optional feature macro: CLOCK_SET_AUTOREPEAT_EN (hold-to-repeat on inc/dec).
module clock_set_ctrl #(
    parameter int TIMEOUT_TICKS = 10,
    parameter int HOLD_CYC      = 50_000_000,
    parameter int REPEAT_CYC    = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    output logic       tick_en,
    output logic       load,
    output logic [4:0] load_hr,
    output logic [5:0] load_min,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    // Reject parameter values the counters cannot represent.
    generate
        if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 63 || HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
            $error("clock_set_ctrl: parameter out of range");
        end
    endgenerate

    state_t     state, next_state;
    logic       prev_mode, prev_inc, prev_dec;
    logic       rise_mode, rise_inc, rise_dec;
    logic       rep_inc, rep_dec;
    logic       inc_ev, dec_ev, any_event;
    logic       in_set, timeout_hit;
    logic [4:0] edit_hr;
    logic [5:0] edit_min;
    logic [5:0] idle_cnt;
    logic       blink_q;

    // Step helpers: wrap at the field limit and pull stray values back in range.
    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
        return (val >= max) ? 6'd0 : val + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] val, input logic [5:0] max);
        return (val == 6'd0 || val > max) ? max : val - 6'd1;
    endfunction

    assign rise_mode = btn_mode & ~prev_mode;
    assign rise_inc  = btn_inc  & ~prev_inc;
    assign rise_dec  = btn_dec  & ~prev_dec;
    assign in_set    = (state == SET_HR) || (state == SET_MIN);

    // Button history for edge detection; resets high so a held button is not an edge.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_mode <= 1'b1;
            prev_inc  <= 1'b1;
            prev_dec  <= 1'b1;
        end else begin
            prev_mode <= btn_mode;
            prev_inc  <= btn_inc;
            prev_dec  <= btn_dec;
        end
    end

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] hold_cnt;
    logic          repeating;
    logic          hold_ok, rep_fire;
    int            hold_limit;

    // Exactly one step button held in a SET state, not overridden by mode.
    assign hold_ok    = in_set && (btn_inc ^ btn_dec) && !rise_mode;
    assign hold_limit = repeating ? REPEAT_CYC : HOLD_CYC;
    assign rep_fire   = hold_ok && !(rise_inc || rise_dec) && (hold_cnt != '0)
                        && (int'(hold_cnt) >= hold_limit);
    assign rep_inc    = rep_fire & btn_inc;
    assign rep_dec    = rep_fire & btn_dec;

    // Hold timer: first step after HOLD_CYC, then one every REPEAT_CYC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (!hold_ok) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (rise_inc || rise_dec) begin
            hold_cnt  <= CW'(1);
            repeating <= 1'b0;
        end else if (rep_fire) begin
            hold_cnt  <= CW'(1);
            repeating <= 1'b1;
        end else if (hold_cnt != '0) begin
            hold_cnt  <= hold_cnt + CW'(1);
        end
    end
`else
    assign rep_inc = 1'b0;
    assign rep_dec = 1'b0;
`endif

    assign inc_ev    = rise_inc | rep_inc;
    assign dec_ev    = rise_dec | rep_dec;
    assign any_event = rise_mode | inc_ev | dec_ev;
    assign timeout_hit = in_set && tick_1hz && !any_event
                         && (({1'b0, idle_cnt} + 7'd1) >= 7'(TIMEOUT_TICKS));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= next_state;
    end

    // Next-state logic: mode rise advances, idle timeout abandons the edit.
    // NOTE: next_state gets a default first so no path through the case
    // leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            RUN:     if (rise_mode) next_state = SET_HR;
            SET_HR:  if (rise_mode) next_state = SET_MIN;
                     else if (timeout_hit) next_state = RUN;
            SET_MIN: if (rise_mode) next_state = COMMIT;
                     else if (timeout_hit) next_state = RUN;
            COMMIT:  next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Outputs decoded from the current state; COMMIT reports as RUN.
    always_comb begin
        mode    = (state == COMMIT) ? 2'd0 : 2'(state);
        load    = (state == COMMIT);
        tick_en = tick_1hz && (state == RUN);
        blink   = blink_q;
    end

    // Edit registers: captured from live time on entry, stepped by inc/dec.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit_hr  <= 5'd0;
            edit_min <= 6'd0;
        end else if (state == RUN && rise_mode) begin
            edit_hr  <= (cur_hr  > 5'd23) ? 5'd0 : cur_hr;
            edit_min <= (cur_min > 6'd59) ? 6'd0 : cur_min;
        end else if (!rise_mode && (inc_ev ^ dec_ev)) begin
            if (state == SET_HR)
                edit_hr  <= inc_ev ? 5'(wrap_inc({1'b0, edit_hr}, 6'd23))
                                   : 5'(wrap_dec({1'b0, edit_hr}, 6'd23));
            else if (state == SET_MIN)
                edit_min <= inc_ev ? wrap_inc(edit_min, 6'd59)
                                   : wrap_dec(edit_min, 6'd59);
        end
    end

    // Load value is latched on the way into COMMIT and held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_hr  <= 5'd0;
            load_min <= 6'd0;
        end else if (state == SET_MIN && next_state == COMMIT) begin
            load_hr  <= edit_hr;
            load_min <= edit_min;
        end
    end

    // Idle counter: ticks while editing, cleared by any button activity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            idle_cnt <= 6'd0;
        else if (any_event || !in_set)
            idle_cnt <= 6'd0;
        else if (tick_1hz && idle_cnt != 6'd63)
            idle_cnt <= idle_cnt + 6'd1;
    end

    // Blink: cleared outside SET states and on entry, toggles on each tick while editing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            blink_q <= 1'b0;
        else if (next_state != state || !in_set)
            blink_q <= 1'b0;
        else if (tick_1hz)
            blink_q <= ~blink_q;
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl with hand-computed expectations.
module tb_clock_set_ctrl;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int TB_HOLD   = 4;
    localparam int TB_REPEAT = 2;
`else
    localparam int TB_HOLD   = 50_000_000;
    localparam int TB_REPEAT = 10_000_000;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b1, btn_inc = 1'b1, btn_dec = 1'b1;
    logic [4:0] cur_hr = 5'd0;
    logic [5:0] cur_min = 6'd0;
    logic       tick_en, load, blink;
    logic [4:0] load_hr;
    logic [5:0] load_min;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int snap;

    clock_set_ctrl #(
        .TIMEOUT_TICKS(10),
        .HOLD_CYC(TB_HOLD),
        .REPEAT_CYC(TB_REPEAT)
    ) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_hr(cur_hr), .cur_min(cur_min),
        .tick_en(tick_en), .load(load), .load_hr(load_hr), .load_min(load_min),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    // Count load strobes, sampled mid-cycle.
    always @(negedge clk) if (load) load_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle button pulse: 0 = mode, 1 = inc, 2 = dec.
    task automatic press(input int which);
        case (which)
            0: btn_mode = 1'b1;
            1: btn_inc  = 1'b1;
            default: btn_dec = 1'b1;
        endcase
        cyc();
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cyc();
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    initial begin
        // Reset held with all buttons high.
        repeat (3) cyc();
        check("rst_mode", mode, 0);
        check("rst_load", load, 0);
        check("rst_blink", blink, 0);
        check("rst_load_hr", load_hr, 0);
        reset = 1'b1;
        repeat (3) cyc();
        check("held_btn_no_move", mode, 0);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cyc();
        tick_1hz = 1'b1;
        #1 check("run_tick_en", tick_en, 1);
        cyc();
        tick_1hz = 1'b0;
        #1 check("run_tick_en_low", tick_en, 0);

        // 23:59 -> inc hours, inc minutes -> 00:00.
        cur_hr = 5'd23; cur_min = 6'd59;
        snap = load_cnt;
        press(0);
        check("enter_set_hr", mode, 1);
        press(1);
        press(0);
        check("enter_set_min", mode, 2);
        press(1);
        btn_mode = 1'b1;
        cyc();
        check("wrap_up_load", load, 1);
        check("wrap_up_load_hr", load_hr, 0);
        check("wrap_up_load_min", load_min, 0);
        check("commit_mode", mode, 0);
        btn_mode = 1'b0;
        cyc();
        check("load_one_cycle", load, 0);
        check("wrap_up_load_cnt", load_cnt - snap, 1);

        // 00:00 -> dec hours once, minutes twice -> 23:58.
        cur_hr = 5'd0; cur_min = 6'd0;
        press(0); press(2); press(0); press(2); press(2);
        btn_mode = 1'b1;
        cyc();
        check("wrap_dn_load_hr", load_hr, 23);
        check("wrap_dn_load_min", load_min, 58);
        btn_mode = 1'b0;
        repeat (3) cyc();
        check("load_hr_hold", load_hr, 23);
        check("load_min_hold", load_min, 58);

        // Simultaneous buttons, blink and tick gating.
        cur_hr = 5'd10; cur_min = 6'd20;
        press(0);
        check("blink_entry", blink, 0);
        tick_1hz = 1'b1;
        #1 check("set_tick_dropped", tick_en, 0);
        cyc();
        tick_1hz = 1'b0;
        check("blink_toggle", blink, 1);
        btn_inc = 1'b1; btn_dec = 1'b1;
        cyc();
        btn_inc = 1'b0; btn_dec = 1'b0;
        cyc();
        btn_mode = 1'b1; btn_inc = 1'b1;
        cyc();
        btn_mode = 1'b0; btn_inc = 1'b0;
        check("mode_beats_inc", mode, 2);
        check("blink_entry_min", blink, 0);
        cyc();
        btn_mode = 1'b1;
        cyc();
        check("simul_load_hr", load_hr, 10);
        check("simul_load_min", load_min, 20);
        btn_mode = 1'b0;
        cyc();

        // Timeout in SET_MIN after 10 idle ticks.
        press(0); press(0);
        snap = load_cnt;
        for (int i = 0; i < 10; i++) begin
            tick_1hz = 1'b1;
            #1 check($sformatf("timeout_tick_en_%0d", i), tick_en, 0);
            cyc();
            tick_1hz = 1'b0;
            check($sformatf("timeout_mode_%0d", i), mode, (i < 9) ? 2 : 0);
            cyc();
        end
        check("timeout_no_load", load_cnt - snap, 0);
        check("timeout_blink", blink, 0);
        check("timeout_load_hr_kept", load_hr, 10);

        // Reset asserted mid-edit.
        cur_hr = 5'd7; cur_min = 6'd30;
        snap = load_cnt;
        press(0); press(1); press(0);
        check("pre_reset_mode", mode, 2);
        reset = 1'b0;
        #1;
        check("reset_mode", mode, 0);
        check("reset_load_hr", load_hr, 0);
        check("reset_load_min", load_min, 0);
        check("reset_blink", blink, 0);
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        check("reset_no_load", load_cnt - snap, 0);
        press(0); press(0);
        btn_mode = 1'b1;
        cyc();
        check("post_reset_load_hr", load_hr, 7);
        btn_mode = 1'b0;
        cyc();

`ifdef CLOCK_SET_AUTOREPEAT_EN
        // Hold inc 10 cycles from 5: rise step plus repeats at 4, 6, 8 -> 9.
        cur_hr = 5'd5; cur_min = 6'd0;
        press(0);
        btn_inc = 1'b1;
        repeat (10) cyc();
        btn_inc = 1'b0;
        cyc();
        press(0);
        btn_mode = 1'b1;
        cyc();
        check("autorepeat_hr", load_hr, 9);
        btn_mode = 1'b0;
        cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
